// File: rtl/mini_cpu_regmem_if.sv
// Operand/write-back bus between the mini-CPU datapath and its register store.
// The master (CPU datapath) drives addresses, write data and control; the
// slave (mini_cpu_regmem) returns the two registered read operands.
interface mini_cpu_regmem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] dest;
  logic              we;
  logic              clear;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] q2;

  modport master (
    output data, addr1, addr2, dest, we, clear,
    input  q, q2
  );

  modport slave (
    input  data, addr1, addr2, dest, we, clear,
    output q, q2
  );
endinterface

// File: rtl/mini_cpu_regmem.sv
// mini_cpu_regmem: DEPTH x DATA_W register store with one write port and two
// registered read ports (src1 -> q, src2 -> q2), plus a bulk clear used by the
// CPU CLEAR instruction. Reset is synchronous and active-high.
//
// Build option: define MINI_CPU_REGMEM_RDW_BYPASS_EN for write-first behaviour
// on a read/write collision (the new data appears on q/q2 at the same edge).
// Left undefined, collisions are read-first (the old word is returned).
// DEPTH must equal 2**ADDR_W so every address is a real word.
module mini_cpu_regmem #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input logic               clk,
  input logic               rst,
  mini_cpu_regmem_if.slave  bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  // Storage update: reset and clear wipe every word, otherwise accept a write.
  always_ff @(posedge clk) begin
    // NOTE: the array is reset word by word on purpose -- rst and clear must
    // zero the whole store, so this cannot be mapped to a reset-less RAM macro.
    if (rst || bus.clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we) begin
      // NOTE: non-blocking assignment keeps the read path below seeing the
      // pre-edge contents, which is exactly the read-first behaviour.
      mem[bus.dest] <= bus.data;
    end
  end

  // Read operand selection, with optional write-first forwarding on collision.
  always_comb begin
    // NOTE: defaults first so no path leaves these unassigned (no latch).
    rd1_next = mem[bus.addr1];
    rd2_next = mem[bus.addr2];
`ifdef MINI_CPU_REGMEM_RDW_BYPASS_EN
    if (bus.we && (bus.addr1 == bus.dest)) begin
      rd1_next = bus.data;
    end
    if (bus.we && (bus.addr2 == bus.dest)) begin
      rd2_next = bus.data;
    end
`else
    // Read-first: a colliding read returns the old word; the new value is
    // visible on the following read.
`endif
  end

  // Registered read ports: forced to zero on reset or clear, else one-cycle read.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      bus.q  <= '0;
      bus.q2 <= '0;
    end else begin
      bus.q  <= rd1_next;
      bus.q2 <= rd2_next;
    end
  end

endmodule

// File: tb/tb_mini_cpu_regmem.sv
// Self-checking bench for mini_cpu_regmem: directed test-plan steps followed by
// randomized cycles, all compared against a behavioural model of the store.
module tb_mini_cpu_regmem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

`ifdef MINI_CPU_REGMEM_RDW_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk;
  logic rst;

  mini_cpu_regmem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mini_cpu_regmem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain array of words plus the expected read registers.
  logic [DATA_W-1:0] model_mem [DEPTH];
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] exp_q2;

  int n_tests;
  int n_fail;

  task automatic check(input string tag, input logic [DATA_W-1:0] observed,
                       input logic [DATA_W-1:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, then compare both ports.
  task automatic cycle(input logic r, input logic c, input logic w,
                       input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] dt,
                       input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                       input string tag);
    rst       = r;
    bus.clear = c;
    bus.we    = w;
    bus.dest  = d;
    bus.data  = dt;
    bus.addr1 = a1;
    bus.addr2 = a2;
    if (r || c) begin
      exp_q  = '0;
      exp_q2 = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end else begin
      exp_q  = (BYPASS && w && a1 == d) ? dt : model_mem[a1];
      exp_q2 = (BYPASS && w && a2 == d) ? dt : model_mem[a2];
      if (w) model_mem[d] = dt;
    end
    @(posedge clk);
    #1;
    check({tag, ".q"},  bus.q,  exp_q);
    check({tag, ".q2"}, bus.q2, exp_q2);
  endtask

  task automatic wr(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] dt, input string tag);
    cycle(1'b0, 1'b0, 1'b1, d, dt, 4'd0, 4'd0, tag);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2, input string tag);
    cycle(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000, a1, a2, tag);
  endtask

  initial begin
    logic [DATA_W-1:0] col_exp;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.clear = 1'b0;
    bus.we    = 1'b0;
    bus.dest  = '0;
    bus.data  = '0;
    bus.addr1 = '0;
    bus.addr2 = '0;
    #2;

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, "reset_init");

    // Reset wipes a written word.
    wr(4'd5, 16'h1234, "rst_wr5");
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, "rst_pulse");
    rd(4'd5, 4'd0, "rst_rd5");
    check("rst_rd5_const", bus.q, 16'h0000);

    // Write and dual read.
    wr(4'd3,  16'h00AA, "wr3");
    wr(4'd15, 16'hBEEF, "wr15");
    rd(4'd3, 4'd15, "dual_rd");
    check("dual_q_const",  bus.q,  16'h00AA);
    check("dual_q2_const", bus.q2, 16'hBEEF);
    rd(4'd15, 4'd15, "same_rd");
    check("same_q_const",  bus.q,  16'hBEEF);
    check("same_q2_const", bus.q2, 16'hBEEF);

    // Read/write collision on port 1.
    wr(4'd7, 16'h1111, "col_pre");
    cycle(1'b0, 1'b0, 1'b1, 4'd7, 16'h2222, 4'd7, 4'd3, "collide");
    col_exp = BYPASS ? 16'h2222 : 16'h1111;
    check("collide_const", bus.q, col_exp);
    rd(4'd7, 4'd7, "col_after");
    check("col_after_const", bus.q, 16'h2222);

    // Collision on port 2 as well.
    cycle(1'b0, 1'b0, 1'b1, 4'd3, 16'h3333, 4'd0, 4'd3, "collide2");

    // Clear beats a simultaneous write.
    for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), DATA_W'(i * 16'h0101), "fill");
    cycle(1'b0, 1'b1, 1'b1, 4'd2, 16'hFFFF, 4'd2, 4'd9, "clear_we");
    for (int i = 0; i < DEPTH; i++) begin
      rd(ADDR_W'(i), ADDR_W'(DEPTH - 1 - i), "clr_rd");
      check("clr_rd_const", bus.q, 16'h0000);
    end

    // we gating: held data/dest with we=0 must not write; addr1 sweep latency.
    for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i), DATA_W'(i * 16'h0101), "refill");
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b0, 4'd4, 16'h5555, 4'd4, 4'd4, "we_off");
    check("we_off_const", bus.q, 16'h0404);
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b0, 1'b0, 1'b0, 4'd4, 16'h5555, ADDR_W'(i), 4'd4, "sweep");

    // Reset overrides a simultaneous write.
    cycle(1'b1, 1'b0, 1'b1, 4'd9, 16'h9999, 4'd9, 4'd9, "rst_we");
    rd(4'd9, 4'd9, "rst_we_rd");
    check("rst_we_const", bus.q, 16'h0000);

    // Randomized traffic, biased toward collisions via a small address set.
    for (int n = 0; n < 400; n++) begin
      logic r, c, w;
      logic [ADDR_W-1:0] d, a1, a2;
      r  = ($urandom_range(0, 49) == 0);
      c  = ($urandom_range(0, 29) == 0);
      w  = $urandom_range(0, 1) == 1;
      d  = ADDR_W'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? d : ADDR_W'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? d : ADDR_W'($urandom);
      cycle(r, c, w, d, DATA_W'($urandom), a1, a2, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mini_cpu_regmem.md
Name: mini_cpu_regmem

Overview:
- 16-word × 16-bit data memory / register store for the mini-CPU datapath.
- One write port: dest, data, we.
- Two synchronous read ports: addr1→q, addr2→q2. These supply the src1/src2 operands to the ALU; the ALU result is written back via dest.
- Bulk clear input supports the CPU CLEAR instruction.

Parameters:
- DATA_W, 16, word width in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  DATA_W  write data.
- addr1  input  ADDR_W  read address, port 1 (src1).
- addr2  input  ADDR_W  read address, port 2 (src2).
- dest  input  ADDR_W  write address.
- we  input  1  write enable.
- clear  input  1  synchronous bulk clear of all words.
- q  output  DATA_W  registered read data, port 1.
- q2  output  DATA_W  registered read data, port 2.

Behaviour:
- One clock; reset is synchronous and active-high.
  - Clock port: clk. Reset port: rst.
  - Polarity and synchronicity are fixed.
- Storage: DEPTH words of DATA_W bits, addresses 0..DEPTH-1. All addresses, including 0, are ordinary read/write words; none is hardwired.
- Reset, sampled at a rising edge with rst=1:
  - all words become 0;
  - q and q2 become 0;
  - rst overrides we and clear in the same cycle.
- Clear, when rst=0 and clear=1:
  - all words become 0 at the edge;
  - q and q2 become 0 at the same edge;
  - a simultaneous we is discarded (clear wins).
- Write, when rst=0, clear=0, we=1: mem[dest] <= data at the edge.
- Read: at every edge with rst=0 and clear=0:
  - q <= mem[addr1];
  - q2 <= mem[addr2].
  - Latency is 1 cycle: the address presented before edge N appears on q/q2 after edge N.
- Read/write collision (addr1 or addr2 equals dest while we=1): result depends on RDW_BYPASS_EN (see Optional Feature).
- Both read ports may address the same word; each returns the same value.
- When we=0, no word changes; q/q2 still update from the current addresses every cycle.
- No handshake: a write is accepted every cycle we=1; back-to-back writes to the same address leave the last value.
- Widths:
  - no arithmetic inside the block;
  - data is stored unmodified;
  - addresses are full range, so no out-of-range case exists when DEPTH = 2**ADDR_W.
- No X is ever driven on q/q2 after the first reset.

Optional Feature:
- Macro: MINI_CPU_REGMEM_RDW_BYPASS_EN.
- Defined (write-first): on a collision, the read port at the colliding address returns the new data in the same edge (q <= data). This lets the CPU read back a just-written result with no stall.
- Not defined (read-first): on a collision, the read port returns the old stored word; the new value is visible on the following read.
- In both builds, clear and rst still force q/q2 to 0.

Test Plan:
- Reset:
  - write 0x1234 to addr 5;
  - assert rst for 1 cycle;
  - read addr1=5, addr2=0 → q=0x0000, q2=0x0000 one cycle later.
- Write and dual read:
  - write 0x00AA @3, then 0xBEEF @15;
  - set addr1=3, addr2=15 → next cycle q=0x00AA, q2=0xBEEF;
  - then addr1=addr2=15 → q=q2=0xBEEF.
- Collision:
  - mem[7]=0x1111; in one cycle, we=1, dest=7, data=0x2222, addr1=7;
  - with macro: q=0x2222 after the edge;
  - without macro: q=0x1111 after the edge, and q=0x2222 after the next edge.
- Clear vs write:
  - fill addrs 0..15 with the value addr*0x0101;
  - in one cycle, clear=1, we=1, dest=2, data=0xFFFF;
  - afterwards every word reads 0x0000, including addr 2.
- we gating:
  - with we=0, dest=4, data=0x5555 held for 3 cycles, mem[4] keeps its prior 0x0404;
  - q tracks an addr1 sweep 0..15 with 1-cycle latency.
- Reset priority:
  - rst=1 together with we=1, dest=9, data=0x9999;
  - afterwards mem[9]=0x0000 and q/q2=0x0000.
